adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Parametrised, synchronous successor to the fixed two-channel XADC reader.
- Consumes the XADC DRP result stream and captures up to INPUTS auxiliary channels, each at a configurable address.
- Averages 2**AVG_LOG2 samples per channel and presents a complete frame on a valid/ready handshake.
- Sits between the xadc_wiz_0 instance and downstream consumers; all logic runs on the 100 MHz clk, with no edge-triggering on drdy.

Parameters:
- BITS, 12: output precision; upper BITS of the 16-bit DRP word are used (1..16).
- INPUTS, 2: number of captured channels (1..16).
- CHAN_ADDR, {7'h16, 7'h1E}: array [INPUTS] of 7-bit DRP channel addresses, index 0 first.
- AVG_LOG2, 0: log2 of samples averaged per channel per frame (0..8); 0 means pass-through.
- THRESH, all 0: array [INPUTS] of BITS-wide high thresholds; used only with ADC_THRESH_EN.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous, active-high reset
- adc_ready  input  1  DRP drdy, one-cycle strobe synchronous to clk
- adc_channel  input  7  channel address of the current result
- adc_data  input  16  DRP do_out word
- out  output  [INPUTS][BITS]  averaged result per channel, registered
- frame_valid  output  1  out holds a complete, unconsumed frame
- frame_ready  input  1  consumer accepts the frame when high with frame_valid
- overrun  output  1  sticky: a completed frame was dropped
- overrun_clr  input  1  clears overrun
- above  output  [INPUTS]  threshold flags (ADC_THRESH_EN only; otherwise tied 0)

Behaviour:
- **Reset** (rst high at a clk edge):
  - out=0, frame_valid=0, overrun=0, above=0.
  - All accumulators and sample counters cleared.
  - Reset mid-frame discards the partial frame; an unconsumed frame is lost and overrun is not set.
- **Sample accept:**
  - adc_ready=1 and adc_channel==CHAN_ADDR[i] → sample s=adc_data[15:16-BITS] is added to acc[i], and cnt[i] increments.
  - Only happens while cnt[i] < 2**AVG_LOG2.
  - Unmatched addresses are ignored.
  - Extra samples for a channel that is already complete in the current frame are ignored.
  - Duplicate addresses in CHAN_ADDR: the lowest index wins.
- **Width:** acc is BITS+AVG_LOG2 wide and cannot overflow. The result is acc>>AVG_LOG2, truncating with no rounding.
- **Collection FSM** (per frame):
  - COLLECT → COMPLETE when every cnt[i] == 2**AVG_LOG2. Checked combinationally on the cycle of the final accepted sample.
  - COMPLETE is a single cycle that transfers results and clears acc/cnt, then returns to COLLECT.
  - A sample arriving in the COMPLETE cycle counts toward the new frame.
- **Latency:** frame_valid rises and out updates on the clk edge after the final sample is accepted (2 edges after that sample's adc_ready).
- **Output handshake:**
  - Transfer occurs on frame_valid & frame_ready.
  - frame_valid drops the next cycle unless a new frame completes in that same cycle; in that case out reloads and frame_valid stays 1.
  - out is stable while frame_valid=1 and frame_ready=0.
- **Overrun:**
  - A new frame completes while frame_valid=1 and frame_ready=0 → the new frame is dropped, out is unchanged, and overrun is set.
  - overrun_clr clears overrun. If a set and a clear occur in the same cycle, set wins.
- No dependency on eos/eoc; channel order within a frame is arbitrary.

Optional Feature:
- Macro: ADC_THRESH_EN.
- Defined:
  - above[i] is registered with out and equals (result_i > THRESH[i]) for the loaded frame.
  - above is cleared by reset.
  - above is unaffected by dropped frames.
- Undefined: above is tied to 0, and no comparators or THRESH logic are generated.

Decomposition:
- Package pkg_adc_capture holds:
  - DRP_ADDR_W=7 and DRP_DATA_W=16.
  - Named addresses VAUX6=7'h16 and VAUX14=7'h1E.
  - Default BITS/INPUTS.
  - typedef sample_t (logic [BITS-1:0]).
- Sub-module adc_accum: one channel's matcher, accumulator, counter and done flag. It is instantiated INPUTS times via generate; the top holds the FSM, output registers, handshake and overrun.

Test Plan:
- **Pass-through** (AVG_LOG2=0, defaults): ch 7'h16 data 16'h1230, then ch 7'h1E data 16'hFFF0 → 2 edges after the second strobe, out[0]=12'h123, out[1]=12'hFFF, frame_valid=1.
- **Averaging** (AVG_LOG2=2): ch 7'h16 words 16'h1230/16'h1240/16'h1250/16'h1260 plus ch 7'h1E 4×16'hFFF0, interleaved → out[0]=12'h124, out[1]=12'hFFF.
- **Ignore rules:** a 5th ch 7'h16 sample mid-frame and a ch 7'h03 sample → no effect on results or timing.
- **Backpressure:** frame_ready=0 across two completed frames → out holds the first frame and overrun=1. Then frame_ready=1 → frame_valid falls. Then overrun_clr → overrun=0.
- **Reset mid-frame:** rst after 2 of 4 samples → all outputs 0. The next frame needs a full 4 samples per channel.
- **ADC_THRESH_EN** (THRESH={12'h800,12'h800}): results 12'h123/12'hFFF → above=2'b10.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared constants and types for the XADC DRP capture block.
// DRP bus widths, named aux-channel addresses and build defaults.
package pkg_adc_capture;

  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;

  localparam logic [DRP_ADDR_W-1:0] VAUX6  = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] VAUX14 = 7'h1E;

  localparam int unsigned DEF_BITS   = 12;
  localparam int unsigned DEF_INPUTS = 2;

  typedef logic [DEF_BITS-1:0] sample_t;

  typedef enum logic {
    ST_COLLECT,
    ST_COMPLETE
  } state_t;

endpackage

// File: rtl/adc_capture_accum.sv
// One channel of adc_capture: sums 2**AVG_LOG2 matched samples per frame.
// i_clear marks the frame-transfer cycle; a sample in that cycle seeds the next frame.
module adc_accum
  import pkg_adc_capture::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_hit,
  input  logic [BITS-1:0] i_sample,
  output logic [BITS-1:0] o_result,
  output logic            o_done_next
);

  localparam int unsigned ACC_W = BITS + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << AVG_LOG2;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_done;
  logic             w_take;
  logic [ACC_W-1:0] w_ext;

  assign w_ext  = ACC_W'(i_sample);
  assign w_done = (r_cnt == FULL);
  // During the clear cycle the counter is still full, yet the sample belongs to the new frame.
  assign w_take = i_hit && (i_clear || !w_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= w_take ? w_ext : '0;
      r_cnt <= w_take ? ONE : '0;
    end else if (w_take) begin
      r_acc <= r_acc + w_ext;
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_result = r_acc[ACC_W-1:AVG_LOG2];

  always_comb begin
    o_done_next = 1'b0;
    if (i_clear) begin
      o_done_next = w_take && (FULL == ONE);
    end else begin
      o_done_next = w_done || (w_take && (r_cnt == FULL - ONE));
    end
  end

endmodule

// File: rtl/adc_capture.sv
// XADC DRP result capture with per-channel averaging and a valid/ready frame output.
// Define ADC_THRESH_EN to generate the per-channel high-threshold flags on 'above'.
module adc_capture
  import pkg_adc_capture::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned INPUTS   = DEF_INPUTS,
  parameter logic [INPUTS-1:0][DRP_ADDR_W-1:0] CHAN_ADDR = {VAUX14, VAUX6},
  parameter int unsigned AVG_LOG2 = 0,
  parameter logic [INPUTS-1:0][BITS-1:0] THRESH = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adc_ready,
  input  logic [DRP_ADDR_W-1:0]        adc_channel,
  input  logic [DRP_DATA_W-1:0]        adc_data,
  output logic [INPUTS-1:0][BITS-1:0]  out,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic [INPUTS-1:0]            above
);

  state_t r_state;

  logic [INPUTS-1:0][BITS-1:0] r_out;
  logic                        r_valid;
  logic                        r_overrun;

  logic [INPUTS-1:0][BITS-1:0] w_result;
  logic [INPUTS-1:0]           w_hit;
  logic [INPUTS-1:0]           w_done_next;
  logic [BITS-1:0]             w_sample;
  logic                        w_clear;
  logic                        w_all_done;
  logic                        w_load;

  assign w_sample   = adc_data[DRP_DATA_W-1 -: BITS];
  assign w_clear    = (r_state == ST_COMPLETE);
  assign w_all_done = &w_done_next;
  assign w_load     = w_clear && (!r_valid || frame_ready);

  generate
    if (BITS < DRP_DATA_W) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^adc_data[DRP_DATA_W-BITS-1:0];
    end
  endgenerate

  // A duplicated address is owned by its lowest index only.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      w_hit[i] = adc_ready && (adc_channel == CHAN_ADDR[i]);
      for (int unsigned j = 0; j < i; j++) begin
        if (CHAN_ADDR[j] == CHAN_ADDR[i]) begin
          w_hit[i] = 1'b0;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_ch
      adc_accum #(
        .BITS     (BITS),
        .AVG_LOG2 (AVG_LOG2)
      ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_hit       (w_hit[gi]),
        .i_sample    (w_sample),
        .o_result    (w_result[gi]),
        .o_done_next (w_done_next[gi])
      );
    end
  endgenerate

`ifdef ADC_THRESH_EN
  logic [INPUTS-1:0] r_above;
  logic [INPUTS-1:0] w_above;

  always_comb begin
    w_above = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      w_above[i] = (w_result[i] > THRESH[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_above <= '0;
    end else if (w_load) begin
      r_above <= w_above;
    end
  end

  assign above = r_above;
`else
  assign above = '0;
`endif

  // Completion is evaluated on the final sample's cycle, so the transfer lands one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_COLLECT;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_all_done ? ST_COMPLETE : ST_COLLECT;

      if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
      if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_load) begin
        r_out   <= w_result;
        r_valid <= 1'b1;
      end else if (w_clear) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign out         = r_out;
  assign frame_valid = r_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: a pass-through instance and a 4-sample averaging instance.
// Define ADC_THRESH_EN to also check the threshold flags.
module tb_adc_capture;
  import pkg_adc_capture::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        adc_ready = 1'b0;
  logic [6:0]  adc_channel = '0;
  logic [15:0] adc_data = '0;
  logic        frame_ready = 1'b0;
  logic        overrun_clr = 1'b0;

  logic [1:0][11:0] out0, out2;
  logic             fv0, fv2, ov0, ov2;
  logic [1:0]       ab0, ab2;

  int n_checks = 0;
  int n_fail   = 0;

  adc_capture #(
    .BITS      (12),
    .INPUTS    (2),
    .CHAN_ADDR ({VAUX14, VAUX6}),
    .AVG_LOG2  (0),
    .THRESH    ({12'h800, 12'h800})
  ) dut0 (
    .clk (clk), .rst (rst), .adc_ready (adc_ready), .adc_channel (adc_channel),
    .adc_data (adc_data), .out (out0), .frame_valid (fv0), .frame_ready (frame_ready),
    .overrun (ov0), .overrun_clr (overrun_clr), .above (ab0)
  );

  adc_capture #(
    .BITS      (12),
    .INPUTS    (2),
    .CHAN_ADDR ({VAUX14, VAUX6}),
    .AVG_LOG2  (2),
    .THRESH    ({12'h800, 12'h800})
  ) dut2 (
    .clk (clk), .rst (rst), .adc_ready (adc_ready), .adc_channel (adc_channel),
    .adc_data (adc_data), .out (out2), .frame_valid (fv2), .frame_ready (frame_ready),
    .overrun (ov2), .overrun_clr (overrun_clr), .above (ab2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] ch, input logic [15:0] d);
    adc_channel = ch;
    adc_data    = d;
    adc_ready   = 1'b1;
    tick(1);
    adc_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_checks++; if (out0 !== 24'h0) begin n_fail++; $display("FAIL reset_out0 got %h exp 000000", out0); end
    n_checks++; if (out2 !== 24'h0) begin n_fail++; $display("FAIL reset_out2 got %h exp 000000", out2); end
    n_checks++; if ({fv0, fv2} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", {fv0, fv2}); end
    n_checks++; if ({ov0, ov2} !== 2'b00) begin n_fail++; $display("FAIL reset_overrun got %b exp 00", {ov0, ov2}); end
    n_checks++; if ({ab0, ab2} !== 4'b0000) begin n_fail++; $display("FAIL reset_above got %b exp 0000", {ab0, ab2}); end
  endtask

  task automatic test_passthrough();
    logic [1:0] exp_ab;
`ifdef ADC_THRESH_EN
    exp_ab = 2'b10;
`else
    exp_ab = 2'b00;
`endif
    do_reset();
    send(7'h16, 16'h1230);
    send(7'h1E, 16'hFFF0);
    n_checks++; if (fv0 !== 1'b0) begin n_fail++; $display("FAIL pt_latency got %b exp 0", fv0); end
    tick(1);
    n_checks++; if (out0[0] !== 12'h123) begin n_fail++; $display("FAIL pt_out0 got %h exp 123", out0[0]); end
    n_checks++; if (out0[1] !== 12'hFFF) begin n_fail++; $display("FAIL pt_out1 got %h exp fff", out0[1]); end
    n_checks++; if (fv0 !== 1'b1) begin n_fail++; $display("FAIL pt_valid got %b exp 1", fv0); end
    n_checks++; if (ab0 !== exp_ab) begin n_fail++; $display("FAIL pt_above got %b exp %b", ab0, exp_ab); end
  endtask

  task automatic test_back_to_back();
    // Frame held from test_passthrough; complete a new one with ready high in its transfer cycle.
    send(7'h16, 16'h4560);
    send(7'h1E, 16'h0120);
    frame_ready = 1'b1;
    tick(1);
    n_checks++; if (out0 !== {12'h012, 12'h456}) begin n_fail++; $display("FAIL b2b_out got %h exp 012456", out0); end
    n_checks++; if (fv0 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", fv0); end
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", ov0); end
    n_checks++; if (ab0 !== 2'b00) begin n_fail++; $display("FAIL b2b_above got %b exp 00", ab0); end
    tick(1);
    n_checks++; if (fv0 !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got %b exp 0", fv0); end
    frame_ready = 1'b0;
  endtask

  task automatic test_averaging();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(7'h16, 16'h1230 + 16'(k * 16'h10));
      send(7'h1E, 16'hFFF0);
    end
    n_checks++; if (fv2 !== 1'b0) begin n_fail++; $display("FAIL avg_latency got %b exp 0", fv2); end
    tick(1);
    n_checks++; if (out2 !== {12'hFFF, 12'h124}) begin n_fail++; $display("FAIL avg_out got %h exp fff124", out2); end
    n_checks++; if (fv2 !== 1'b1) begin n_fail++; $display("FAIL avg_valid got %b exp 1", fv2); end
  endtask

  task automatic test_ignore();
    logic [6:0]  chs [10];
    logic [15:0] dat [10];
    chs = '{7'h16, 7'h16, 7'h03, 7'h1E, 7'h1E, 7'h16, 7'h16, 7'h16, 7'h1E, 7'h03};
    dat = '{16'h1230, 16'h1240, 16'hABCD, 16'hFFF0, 16'hFFF0, 16'h1250, 16'h1260, 16'hFFF0, 16'hFFF0, 16'h0000};
    do_reset();
    for (int k = 0; k < 10; k++) send(chs[k], dat[k]);
    tick(2);
    n_checks++; if (fv2 !== 1'b0) begin n_fail++; $display("FAIL ign_early got %b exp 0", fv2); end
    send(7'h1E, 16'hFFF0);
    n_checks++; if (fv2 !== 1'b0) begin n_fail++; $display("FAIL ign_latency got %b exp 0", fv2); end
    tick(1);
    n_checks++; if (out2 !== {12'hFFF, 12'h124}) begin n_fail++; $display("FAIL ign_out got %h exp fff124", out2); end
    n_checks++; if (fv2 !== 1'b1) begin n_fail++; $display("FAIL ign_valid got %b exp 1", fv2); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(7'h16, 16'h1230);
      send(7'h1E, 16'hFFF0);
    end
    tick(1);
    n_checks++; if (out2 !== {12'hFFF, 12'h123}) begin n_fail++; $display("FAIL bp_first got %h exp fff123", out2); end
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovr got %b exp 0", ov2); end
    for (int k = 0; k < 4; k++) begin
      send(7'h16, 16'h2000);
      send(7'h1E, 16'h1000);
    end
    tick(1);
    n_checks++; if (out2 !== {12'hFFF, 12'h123}) begin n_fail++; $display("FAIL bp_hold got %h exp fff123", out2); end
    n_checks++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b exp 1", ov2); end
    n_checks++; if (fv2 !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", fv2); end
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    n_checks++; if (fv2 !== 1'b0) begin n_fail++; $display("FAIL bp_consume got %b exp 0", fv2); end
    n_checks++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b exp 1", ov2); end
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL bp_clear got %b exp 0", ov2); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(7'h16, 16'h1230);
      send(7'h1E, 16'hFFF0);
    end
    tick(1);
    for (int k = 0; k < 2; k++) begin
      send(7'h16, 16'h1230);
      send(7'h1E, 16'hFFF0);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if (out2 !== 24'h0) begin n_fail++; $display("FAIL rm_out got %h exp 000000", out2); end
    n_checks++; if ({fv2, ov2} !== 2'b00) begin n_fail++; $display("FAIL rm_flags got %b exp 00", {fv2, ov2}); end
    for (int k = 0; k < 4; k++) send(7'h16, 16'h4000);
    for (int k = 0; k < 3; k++) send(7'h1E, 16'hFFF0);
    tick(2);
    n_checks++; if (fv2 !== 1'b0) begin n_fail++; $display("FAIL rm_partial got %b exp 0", fv2); end
    send(7'h1E, 16'hFFF0);
    tick(1);
    n_checks++; if (out2 !== {12'hFFF, 12'h400}) begin n_fail++; $display("FAIL rm_out_new got %h exp fff400", out2); end
    n_checks++; if (fv2 !== 1'b1) begin n_fail++; $display("FAIL rm_valid got %b exp 1", fv2); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_averaging();
    test_ignore();
    test_backpressure();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
